// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan driver.
// Digit codes, the blank code, and the packed-bus field locator.
package led_scan_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t BCD_BLANK = 4'hF;

   function automatic int unsigned digit_lsb(input int unsigned i);
      return 4 * i;
   endfunction

endpackage

// File: rtl/led_scan_driver_if.sv
// Display-side bundle of the scan driver: packed digits in, segment bus out.
// master is the driver, slave is whatever feeds digits and watches the bus.
interface led_scan_driver_if #(
   parameter int NUM_DIGITS = 8
);
   import led_scan_pkg::*;

   logic [4*NUM_DIGITS-1:0] digits_bcd;
   logic [NUM_DIGITS-1:0]   dp_en;
   logic                    lz_blank_en;
   digit_t                  bcd;
   logic                    led_seg_h_n;
   logic [NUM_DIGITS-1:0]   led_sel_n;
   logic                    frame_tick;

   modport master (
      input  digits_bcd,
      input  dp_en,
      input  lz_blank_en,
      output bcd,
      output led_seg_h_n,
      output led_sel_n,
      output frame_tick
   );

   modport slave (
      output digits_bcd,
      output dp_en,
      output lz_blank_en,
      input  bcd,
      input  led_seg_h_n,
      input  led_sel_n,
      input  frame_tick
   );

endinterface

// File: rtl/scan_prescaler.sv
// Slot timer and digit index for the scan driver.
// Wraps by explicit compare so non-power-of-2 sizes work.
module scan_prescaler #(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 50000,
   parameter int GAP_CYCLES = 2500,
   localparam int IW = $clog2(NUM_DIGITS),
   localparam int CW = $clog2(SCAN_DIV)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          in_gap,
   output logic [IW-1:0] idx,
   output logic          frame_start
);

   logic [CW-1:0] cnt;
   logic          slot_end;
   logic          idx_end;

   assign slot_end    = (cnt == CW'(SCAN_DIV - 1));
   assign idx_end     = (idx == IW'(NUM_DIGITS - 1));
   assign in_gap      = (cnt < CW'(GAP_CYCLES));
   assign frame_start = (cnt == '0) && (idx == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= idx_end ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_scan_driver.sv
// Multiplexes packed BCD digits onto one shared 7-segment bus.
// Digits are latched once per frame so a refresh never mixes two values.
module led_scan_driver
   import led_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 50000,
   parameter int GAP_CYCLES = 2500,
   localparam int IW = $clog2(NUM_DIGITS)
) (
   input  logic clk,
   input  logic rst_n,
   led_scan_driver_if.master io
);

   logic                    in_gap;
   logic [IW-1:0]           idx;
   logic                    frame_start;
   logic [4*NUM_DIGITS-1:0] snap;
   digit_t                  dig [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   blank;
   logic [NUM_DIGITS-1:0]   sel_nxt;
   logic                    all_zero;

   scan_prescaler #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV),
      .GAP_CYCLES (GAP_CYCLES)
   ) u_prescaler (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_gap      (in_gap),
      .idx         (idx),
      .frame_start (frame_start)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         snap <= '0;
      end else if (frame_start) begin
         snap <= io.digits_bcd;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      assign dig[g]     = snap[digit_lsb(g) +: 4];
      assign sel_nxt[g] = !(idx == IW'(g));
   end

   // Walk down from the top digit; digit 0 always shows.
   always_comb begin
      all_zero = 1'b1;
      blank    = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         all_zero = all_zero & (dig[i] == '0);
         blank[i] = io.lz_blank_en & all_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         io.led_sel_n   <= '1;
         io.bcd         <= BCD_BLANK;
         io.led_seg_h_n <= 1'b1;
         io.frame_tick  <= 1'b0;
      end else begin
         io.frame_tick <= frame_start;
         if (in_gap) begin
            io.led_sel_n   <= '1;
            io.bcd         <= BCD_BLANK;
            io.led_seg_h_n <= 1'b1;
         end else begin
            io.led_sel_n   <= sel_nxt;
            io.bcd         <= blank[idx] ? BCD_BLANK : dig[idx];
            io.led_seg_h_n <= ~io.dp_en[idx];
         end
      end
   end

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver: directed phases plus random traffic,
// checked every cycle against a frame-arithmetic reference model.
module tb_led_scan_driver;

   localparam int N   = 4;
   localparam int SD  = 8;
   localparam int GAP = 2;
   localparam int FR  = N * SD;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   led_scan_driver_if #(.NUM_DIGITS(N)) io ();

   led_scan_driver #(
      .NUM_DIGITS (N),
      .SCAN_DIV   (SD),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   int            n_chk  = 0;
   int            n_pass = 0;
   string         phase  = "init";
   int            m_t    = 0;
   logic [4*N-1:0] m_snap = '0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s/%s t=%0d got=%h want=%h",
                    phase, tag, m_t, obs, exp);
   endtask

   function automatic logic [3:0] digit_of(input logic [4*N-1:0] s,
                                           input int i);
      logic [4*N-1:0] sh;
      sh = s >> (4 * i);
      return sh[3:0];
   endfunction

   // Highest non-zero digit position, -1 when all digits are zero.
   function automatic int top_nz(input logic [4*N-1:0] s);
      for (int i = N - 1; i >= 0; i--)
         if (digit_of(s, i) != 4'h0) return i;
      return -1;
   endfunction

   task automatic step();
      logic [N-1:0] e_sel;
      logic [3:0]   e_bcd;
      logic         e_dp;
      logic         e_tick;
      int           c;
      int           ix;
      e_sel  = '1;
      e_bcd  = 4'hF;
      e_dp   = 1'b1;
      e_tick = 1'b0;
      if (rst_n) begin
         c      = m_t % SD;
         ix     = (m_t / SD) % N;
         e_tick = (m_t % FR) == 0;
         if (c >= GAP) begin
            e_sel[ix] = 1'b0;
            e_bcd     = digit_of(m_snap, ix);
            if (io.lz_blank_en && ix > 0 && ix > top_nz(m_snap))
               e_bcd = 4'hF;
            e_dp = ~io.dp_en[ix];
         end
         if ((m_t % FR) == 0) m_snap = io.digits_bcd;
         m_t++;
      end else begin
         m_t    = 0;
         m_snap = '0;
      end
      @(posedge clk);
      #1;
      check("sel",  32'(io.led_sel_n),   32'(e_sel));
      check("bcd",  32'(io.bcd),         32'(e_bcd));
      check("dp",   32'(io.led_seg_h_n), 32'(e_dp));
      check("tick", 32'(io.frame_tick),  32'(e_tick));
      check("onehot", 32'($countones(~io.led_sel_n) <= 1), 32'd1);
   endtask

   task automatic rand_inputs();
      logic [31:0]    r;
      logic [4*N-1:0] d;
      int             k;
      r = $urandom;
      d = r[4*N-1:0];
      k = $urandom_range(0, N);
      for (int i = N - k; i < N; i++) d[4*i +: 4] = 4'h0;
      io.digits_bcd  = d;
      io.dp_en       = N'($urandom);
      io.lz_blank_en = 1'($urandom);
   endtask

   initial begin
      rst_n          = 1'b0;
      io.digits_bcd  = 16'h1234;
      io.dp_en       = '0;
      io.lz_blank_en = 1'b0;

      phase = "reset";
      repeat (3) step();

      phase = "scan";
      rst_n = 1'b1;
      repeat (2 * FR) step();

      phase = "lz0050";
      io.lz_blank_en = 1'b1;
      io.digits_bcd  = 16'h0050;
      repeat (2 * FR) step();

      phase = "lz0000";
      io.digits_bcd = 16'h0000;
      repeat (2 * FR) step();

      phase = "lzoff";
      io.lz_blank_en = 1'b0;
      repeat (2 * FR) step();

      phase = "snap";
      io.digits_bcd = 16'h1111;
      while ((m_t % FR) != 0) step();
      repeat (FR) step();
      while (((m_t / SD) % N) != 2) step();
      io.digits_bcd = 16'h2222;
      repeat (2 * FR) step();

      phase = "dp";
      io.dp_en = 4'b0010;
      repeat (FR) step();
      io.dp_en = '0;

      phase = "midrst";
      while ((m_t % FR) != 2 * SD + 5) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (2 * FR) step();

      phase = "random";
      repeat (3000) begin
         if ($urandom_range(0, 15) == 0) rand_inputs();
         rst_n = ($urandom_range(0, 399) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
